// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common data bus arbiter and driver. Each functional unit owns a
//   single-entry result slot; every cycle up to CDB_W valid slots are
//   granted in round-robin order (starting at rr_ptr) and broadcast on the
//   registered CDB ports during the following cycle.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   fu_done      FU i presents a completed result this cycle
//   fu_tag       destination physical register per FU (packed, FU0 in LSBs)
//   fu_result    result value per FU
//   fu_rob_idx   ROB entry per FU
//   flush        mispredict squash; drops pending results and this cycle's fu_done
//   fu_free      FU i may assert fu_done this cycle (empty slot or slot being granted)
//   cdb_valid    broadcast valid per CDB port (port 0 = earlier in RR order)
//   cdb_tag      broadcast tag per port
//   cdb_value    broadcast value per port
//   cdb_rob_idx  broadcast ROB index per port
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int CDB_W     = 2,
    parameter int PRF_IDX_W = 7,
    parameter int ROB_IDX_W = 5,
    parameter int VAL_W     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FU-1:0]             fu_done,
    input  logic [NUM_FU*PRF_IDX_W-1:0]   fu_tag,
    input  logic [NUM_FU*VAL_W-1:0]       fu_result,
    input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx,
    input  logic                          flush,
    output logic [NUM_FU-1:0]             fu_free,
    output logic [CDB_W-1:0]              cdb_valid,
    output logic [CDB_W*PRF_IDX_W-1:0]    cdb_tag,
    output logic [CDB_W*VAL_W-1:0]        cdb_value,
    output logic [CDB_W*ROB_IDX_W-1:0]    cdb_rob_idx
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]    slot_valid_r;
    logic [PRF_IDX_W-1:0] slot_tag_r   [NUM_FU];
    logic [VAL_W-1:0]     slot_value_r [NUM_FU];
    logic [ROB_IDX_W-1:0] slot_rob_r   [NUM_FU];
    logic [PTR_W-1:0]     rr_ptr_r;

    logic [NUM_FU-1:0]    grant_s;
    logic [CDB_W-1:0]     port_vld_s;
    logic [PTR_W-1:0]     port_idx_s [CDB_W];
    logic [PTR_W-1:0]     ptr_next_s;

    // Round-robin scan of the slots: the n-th valid slot found from rr_ptr goes to port n.
    always_comb begin
        int n;
        int idx;
        n          = 0;
        idx        = 0;
        grant_s    = '0;
        port_vld_s = '0;
        ptr_next_s = rr_ptr_r;
        for (int p = 0; p < CDB_W; p++) begin
            port_idx_s[p] = '0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr_r) + k) % NUM_FU;
            if (slot_valid_r[idx] && (n < CDB_W)) begin
                grant_s[idx]  = 1'b1;
                port_vld_s[n] = 1'b1;
                port_idx_s[n] = PTR_W'(idx);
                // The last grant found so far determines the next starting point.
                ptr_next_s    = PTR_W'((idx + 1) % NUM_FU);
                n             = n + 1;
            end else begin
                // Slot empty or every port already granted: nothing to record.
                grant_s[idx] = grant_s[idx];
            end
        end
    end

    // A slot can accept a new result when empty or when it drains this cycle;
    // deliberately independent of fu_done so no combinational loop forms.
    assign fu_free = ~slot_valid_r | grant_s;

    // Slot occupancy: flush/reset clear, accepted result loads, grant empties.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            slot_valid_r <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_done[i] && fu_free[i]) begin
                    slot_valid_r[i] <= 1'b1;
                end else if (grant_s[i]) begin
                    slot_valid_r[i] <= 1'b0;
                end else begin
                    slot_valid_r[i] <= slot_valid_r[i];
                end
            end
        end
    end

    // Slot payload capture; contents are only meaningful while the slot is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (!reset && !flush && fu_done[i] && fu_free[i]) begin
                slot_tag_r[i]   <= fu_tag[i*PRF_IDX_W +: PRF_IDX_W];
                slot_value_r[i] <= fu_result[i*VAL_W +: VAL_W];
                slot_rob_r[i]   <= fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            end else begin
                slot_tag_r[i]   <= slot_tag_r[i];
                slot_value_r[i] <= slot_value_r[i];
                slot_rob_r[i]   <= slot_rob_r[i];
            end
        end
    end

    // Registered CDB ports; a flush suppresses the broadcast of this cycle's grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_rob_idx <= '0;
        end else if (flush) begin
            cdb_valid   <= '0;
        end else begin
            cdb_valid <= port_vld_s;
            for (int p = 0; p < CDB_W; p++) begin
                if (port_vld_s[p]) begin
                    cdb_tag[p*PRF_IDX_W +: PRF_IDX_W]     <= slot_tag_r[port_idx_s[p]];
                    cdb_value[p*VAL_W +: VAL_W]           <= slot_value_r[port_idx_s[p]];
                    cdb_rob_idx[p*ROB_IDX_W +: ROB_IDX_W] <= slot_rob_r[port_idx_s[p]];
                end else begin
                    cdb_tag[p*PRF_IDX_W +: PRF_IDX_W]     <= cdb_tag[p*PRF_IDX_W +: PRF_IDX_W];
                    cdb_value[p*VAL_W +: VAL_W]           <= cdb_value[p*VAL_W +: VAL_W];
                    cdb_rob_idx[p*ROB_IDX_W +: ROB_IDX_W] <= cdb_rob_idx[p*ROB_IDX_W +: ROB_IDX_W];
                end
            end
        end
    end

    // Round-robin pointer: advances past the last grant; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (flush) begin
            rr_ptr_r <= rr_ptr_r;
        end else begin
            rr_ptr_r <= ptr_next_s;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int PW = 7;
    localparam int RW = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic [NF-1:0]      fu_done;
    logic [NF*PW-1:0]   fu_tag;
    logic [NF*64-1:0]   fu_result;
    logic [NF*RW-1:0]   fu_rob_idx;
    logic               flush;
    logic [NF-1:0]      fu_free;
    logic [1:0]         cdb_valid;
    logic [2*PW-1:0]    cdb_tag;
    logic [2*64-1:0]    cdb_value;
    logic [2*RW-1:0]    cdb_rob_idx;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .fu_done     (fu_done),
        .fu_tag      (fu_tag),
        .fu_result   (fu_result),
        .fu_rob_idx  (fu_rob_idx),
        .flush       (flush),
        .fu_free     (fu_free),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .cdb_rob_idx (cdb_rob_idx)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // per-FU input payload for the next tick
    logic [PW-1:0] in_tag [NF];
    logic [63:0]   in_val [NF];
    logic [RW-1:0] in_rob [NF];

    // reference model: one result box per FU, a list of pending FUs in RR order
    bit            m_valid [NF];
    logic [PW-1:0] m_tag   [NF];
    logic [63:0]   m_val   [NF];
    logic [RW-1:0] m_rob   [NF];
    int            m_ptr;
    bit            m_cv    [2];
    logic [PW-1:0] m_ct    [2];
    logic [63:0]   m_cval  [2];
    logic [RW-1:0] m_crob  [2];
    int            m_order [$];

    int fcount [NF];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pending FUs visited from the pointer, at most two of them win
    function automatic void m_compute();
        m_order.delete();
        for (int k = 0; k < NF; k++) begin
            int f;
            f = (m_ptr + k) % NF;
            if (m_valid[f] && m_order.size() < 2) m_order.push_back(f);
        end
    endfunction

    function automatic logic [NF-1:0] m_free_vec();
        logic [NF-1:0] v;
        v = '0;
        for (int i = 0; i < NF; i++) v[i] = !m_valid[i];
        foreach (m_order[j]) v[m_order[j]] = 1'b1;
        return v;
    endfunction

    function automatic void m_step(input logic [NF-1:0] d, input bit fl, input bit rs);
        logic [NF-1:0] fr;
        logic [NF-1:0] won;
        m_compute();
        fr  = m_free_vec();
        won = '0;
        foreach (m_order[j]) won[m_order[j]] = 1'b1;
        if (rs) begin
            for (int i = 0; i < NF; i++) m_valid[i] = 0;
            for (int p = 0; p < 2; p++) begin
                m_cv[p] = 0; m_ct[p] = '0; m_cval[p] = '0; m_crob[p] = '0;
            end
            m_ptr = 0;
        end else if (fl) begin
            for (int i = 0; i < NF; i++) m_valid[i] = 0;
            m_cv[0] = 0; m_cv[1] = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (p < m_order.size()) begin
                    m_cv[p]   = 1;
                    m_ct[p]   = m_tag[m_order[p]];
                    m_cval[p] = m_val[m_order[p]];
                    m_crob[p] = m_rob[m_order[p]];
                end else begin
                    m_cv[p] = 0;
                end
            end
            if (m_order.size() > 0) m_ptr = (m_order[m_order.size()-1] + 1) % NF;
            for (int i = 0; i < NF; i++) begin
                if (d[i] && fr[i]) begin
                    m_valid[i] = 1; m_tag[i] = in_tag[i]; m_val[i] = in_val[i]; m_rob[i] = in_rob[i];
                end else if (won[i]) begin
                    m_valid[i] = 0;
                end
            end
        end
    endfunction

    task automatic check_model();
        m_compute();
        chk("cdb_valid", 64'(cdb_valid), 64'({m_cv[1], m_cv[0]}));
        chk("port1_without_port0", 64'(cdb_valid == 2'b10), 64'd0);
        for (int p = 0; p < 2; p++) begin
            if (m_cv[p]) begin
                chk($sformatf("cdb_tag[%0d]", p), 64'(cdb_tag[p*PW +: PW]), 64'(m_ct[p]));
                chk($sformatf("cdb_value[%0d]", p), cdb_value[p*64 +: 64], m_cval[p]);
                chk($sformatf("cdb_rob_idx[%0d]", p), 64'(cdb_rob_idx[p*RW +: RW]), 64'(m_crob[p]));
            end
        end
        chk("fu_free", 64'(fu_free), 64'(m_free_vec()));
    endtask

    // drive one cycle of inputs (at the falling edge), step the model, check after the edge
    task automatic tick(input logic [NF-1:0] d, input bit fl = 1'b0, input bit rs = 1'b0);
        fu_done = d;
        flush   = fl;
        reset   = rs;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i*PW +: PW]     = in_tag[i];
            fu_result[i*64 +: 64]  = in_val[i];
            fu_rob_idx[i*RW +: RW] = in_rob[i];
        end
        m_step(d, fl, rs);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic set_payload(input int base);
        for (int i = 0; i < NF; i++) begin
            in_tag[i] = PW'(i*16 + base);
            in_val[i] = {$urandom, $urandom};
            in_rob[i] = RW'(i + base);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; fu_done = '0;
        fu_tag = '0; fu_result = '0; fu_rob_idx = '0;
        for (int i = 0; i < NF; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_val[i] = '0; m_rob[i] = '0; fcount[i] = 0;
        end
        m_ptr = 0;
        set_payload(1);
        @(negedge clk);

        // reset held 3 cycles with every FU claiming done
        for (int c = 0; c < 3; c++) tick(4'b1111, 1'b0, 1'b1);
        chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("reset_fu_free", 64'(fu_free), 64'hF);
        chk("reset_cdb_tag", 64'(cdb_tag), 64'd0);
        tick(4'b0000);
        chk("post_reset_no_bcast", 64'(cdb_valid), 64'd0);

        // all four done together with rr_ptr=0
        set_payload(2);
        tick(4'b1111);
        chk("all4_free_t1", 64'(fu_free), 64'b0011);
        tick(4'b0000);
        chk("all4_valid_t2", 64'(cdb_valid), 64'b11);
        chk("all4_p0_t2", 64'(cdb_tag[0 +: PW]), 64'(7'd2));
        chk("all4_p1_t2", 64'(cdb_tag[PW +: PW]), 64'(7'd18));
        chk("all4_free_t2", 64'(fu_free), 64'b1111);
        tick(4'b0000);
        chk("all4_p0_t3", 64'(cdb_tag[0 +: PW]), 64'(7'd34));
        chk("all4_p1_t3", 64'(cdb_tag[PW +: PW]), 64'(7'd50));

        // fairness: every FU done for 8 cycles; bits [5:4] of the tag name the FU
        for (int k = 0; k < 12; k++) begin
            set_payload(k % 16);
            tick((k < 8) ? 4'b1111 : 4'b0000);
            if (k >= 1 && k <= 8) begin
                for (int p = 0; p < 2; p++)
                    if (cdb_valid[p]) fcount[int'(cdb_tag[p*PW+4 +: 2])]++;
            end
        end
        for (int i = 0; i < NF; i++) chk($sformatf("fair_count_fu%0d", i), 64'(fcount[i]), 64'd4);

        // single result from FU2; pointer then starts at FU3
        in_tag[2] = 7'h15; in_rob[2] = 5'd9; in_val[2] = 64'hDEAD_BEEF_0000_0002;
        tick(4'b0100);
        tick(4'b0000);
        chk("single_valid", 64'(cdb_valid), 64'b01);
        chk("single_tag", 64'(cdb_tag[0 +: PW]), 64'h15);
        chk("single_rob", 64'(cdb_rob_idx[0 +: RW]), 64'd9);
        set_payload(1);
        tick(4'b1111);
        tick(4'b0000);
        chk("rr_after_single_p0", 64'(cdb_tag[0 +: PW]), 64'(7'd49));
        chk("rr_after_single_p1", 64'(cdb_tag[PW +: PW]), 64'(7'd1));
        for (int k = 0; k < 3; k++) tick(4'b0000);

        // flush in the cycle slots 1 and 3 are granted, with a new FU0 result
        set_payload(3);
        tick(4'b1010);
        tick(4'b0001, 1'b1);
        chk("flush_no_bcast", 64'(cdb_valid), 64'd0);
        chk("flush_free", 64'(fu_free), 64'hF);
        tick(4'b0000);
        chk("flush_no_bcast_later", 64'(cdb_valid), 64'd0);
        tick(4'b0000);

        // streaming from FU1 every cycle
        for (int k = 1; k <= 10; k++) begin
            in_tag[1] = PW'(k);
            tick(4'b0010);
            chk("stream_free1", 64'(fu_free[1]), 64'd1);
            if (k >= 2) begin
                chk("stream_valid", 64'(cdb_valid), 64'b01);
                chk("stream_tag", 64'(cdb_tag[0 +: PW]), 64'(k - 1));
            end
        end
        for (int k = 0; k < 3; k++) tick(4'b0000);

        // random traffic, including protocol violations, flushes and resets
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NF; i++) begin
                in_tag[i] = PW'($urandom);
                in_val[i] = {$urandom, $urandom};
                in_rob[i] = RW'($urandom);
            end
            tick(NF'($urandom_range(0, 15)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
